// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared adder constants and the reference {cout,sum} model.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

   localparam int DEFAULT_ADDER_WIDTH = 1;
   localparam int MAX_ADDER_WIDTH     = 64;

   // Result bits [width-1:0] hold the sum and bit [width] the carry out.
   function automatic logic [MAX_ADDER_WIDTH:0] adder_ref(
      input logic [MAX_ADDER_WIDTH-1:0] a,
      input logic [MAX_ADDER_WIDTH-1:0] b,
      input logic                       cin,
      input int unsigned                width
   );
      logic [MAX_ADDER_WIDTH:0] mask;
      logic [MAX_ADDER_WIDTH:0] full;
      mask = (65'd1 << width) - 65'd1;
      full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, cin};
      return full & ((mask << 1) | 65'd1);
   endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bit
//  Description : Combinational 1-bit full adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   logic w_prop;

   assign w_prop = a_i ^ b_i;
   assign sum_o  = w_prop ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & w_prop);

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : Registered WIDTH-bit ripple-carry adder, one-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;

   logic [WIDTH-1:0] sum_d,   sum_q;
   logic             cout_d,  cout_q;
   logic             valid_d, valid_q;

   assign w_carry[0] = cin;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder_bit u_bit (
         .a_i    (a[gi]),
         .b_i    (b[gi]),
         .cin_i  (w_carry[gi]),
         .sum_o  (w_sum[gi]),
         .cout_o (w_carry[gi+1])
      );
   end

   // Idle cycles hold the last result so unqualified inputs never reach the outputs.
   always_comb begin
      sum_d   = sum_q;
      cout_d  = cout_q;
      valid_d = 1'b0;
      if (in_valid) begin
         sum_d   = w_sum;
         cout_d  = w_carry[WIDTH];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         valid_q <= valid_d;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = valid_q;

endmodule : full_adder_cell
`default_nettype wire

// File: tb/tb_full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_cell
//  Description : Scoreboard bench for full_adder_cell at WIDTH 1, 4 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_cell;
   import adder_pkg::*;

   logic clk;
   logic rst;

   logic       iv1, a1, b1, cin1, sum1, cout1, ov1;
   logic       iv4, cin4, cout4, ov4;
   logic [3:0] a4, b4, sum4;
   logic       iv8, cin8, cout8, ov8;
   logic [7:0] a8, b8, sum8;

   logic [1:0] q1[$];
   logic [4:0] q4[$];
   logic [8:0] q8[$];

   int n_checks = 0;
   int n_pass   = 0;

   full_adder_cell #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
      .sum(sum1), .cout(cout1), .out_valid(ov1));
   full_adder_cell #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
      .sum(sum4), .cout(cout4), .out_valid(ov4));
   full_adder_cell #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
      .sum(sum8), .cout(cout8), .out_valid(ov8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: pop the oldest expectation whenever a DUT presents a result.
   always @(negedge clk) begin
      if (ov1 === 1'b1) begin
         if (q1.size() == 0) check("w1 unexpected out_valid", 64'(ov1), 64'd0);
         else check("w1 result {cout,sum}", 64'({cout1, sum1}), 64'(q1.pop_front()));
      end
      if (ov4 === 1'b1) begin
         if (q4.size() == 0) check("w4 unexpected out_valid", 64'(ov4), 64'd0);
         else check("w4 result {cout,sum}", 64'({cout4, sum4}), 64'(q4.pop_front()));
      end
      if (ov8 === 1'b1) begin
         if (q8.size() == 0) check("w8 unexpected out_valid", 64'(ov8), 64'd0);
         else check("w8 result {cout,sum}", 64'({cout8, sum8}), 64'(q8.pop_front()));
      end
   end

   task automatic drive1(input logic a, input logic b, input logic c,
                         input logic es, input logic ec);
      iv1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      q1.push_back({ec, es});
      tick();
   endtask

   task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] es, input logic ec);
      iv4 = 1'b1; a4 = a; b4 = b; cin4 = c;
      q4.push_back({ec, es});
      tick();
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp);
      iv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
      q8.push_back(exp);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  exp_s1;
      logic [7:0]  exp_c1;
      logic [64:0] ref_r;
      logic [7:0]  ra, rb;
      logic        rc;
      exp_s1 = 8'b1001_0110;   // sum for abc = 000..111 (bit index = abc)
      exp_c1 = 8'b1110_1000;   // cout for abc = 000..111

      rst = 1'b1;
      iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      iv4 = 1'b0; a4 = '0;   b4 = '0;   cin4 = 1'b0;
      iv8 = 1'b0; a8 = '0;   b8 = '0;   cin8 = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("reset w1 out_valid", 64'(ov1), 64'd0);
      check("reset w1 {cout,sum}", 64'({cout1, sum1}), 64'd0);
      check("reset w4 {cout,sum,valid}", 64'({cout4, sum4, ov4}), 64'd0);
      check("reset w8 {cout,sum,valid}", 64'({cout8, sum8, ov8}), 64'd0);
      tick();
      rst = 1'b0;

      // WIDTH=1 exhaustive, back-to-back
      for (int i = 0; i < 8; i++) begin
         logic [2:0] abc;
         abc = 3'(i);
         drive1(abc[2], abc[1], abc[0], exp_s1[i], exp_c1[i]);
      end
      iv1 = 1'b0;
      tick();

      // Reset with valid inputs present: nothing is produced
      rst = 1'b1; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         check("w1 in reset out_valid", 64'(ov1), 64'd0);
         check("w1 in reset {cout,sum}", 64'({cout1, sum1}), 64'd0);
      end
      tick();
      rst = 1'b0;
      q1.push_back(2'b11);
      tick();
      iv1 = 1'b0;
      @(negedge clk);
      check("w1 first result after reset valid", 64'(ov1), 64'd1);
      tick();

      // WIDTH=4 wrap-around cases then idle hold
      drive4(4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
      drive4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
      drive4(4'h5, 4'h3, 1'b0, 4'h8, 1'b0);
      iv4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
         tick();
         @(negedge clk);
         check("w4 idle out_valid", 64'(ov4), 64'd0);
         check("w4 idle sum hold", 64'(sum4), 64'h8);
         check("w4 idle cout hold", 64'(cout4), 64'd0);
      end
      tick();

      // Mid-stream reset: the vector sampled alongside rst is discarded
      drive4(4'h1, 4'h2, 1'b0, 4'h3, 1'b0);
      iv4 = 1'b1; a4 = 4'h7; b4 = 4'h7; cin4 = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; iv4 = 1'b0;
      @(negedge clk);
      check("w4 mid-reset out_valid", 64'(ov4), 64'd0);
      check("w4 mid-reset {cout,sum}", 64'({cout4, sum4}), 64'd0);
      tick();
      @(negedge clk);
      check("w4 discarded result not emitted", 64'(ov4), 64'd0);
      tick();

      // WIDTH=8 directed edge, then random back-to-back against the reference
      drive8(8'hFF, 8'h01, 1'b0, 9'h100);
      drive8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         ref_r = adder_ref({56'd0, ra}, {56'd0, rb}, rc, 8);
         drive8(ra, rb, rc, ref_r[8:0]);
      end
      iv8 = 1'b0;
      repeat (2) tick();

      check("w1 scoreboard drained", 64'(q1.size()), 64'd0);
      check("w4 scoreboard drained", 64'(q4.size()), 64'd0);
      check("w8 scoreboard drained", 64'(q8.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_full_adder_cell
`default_nettype wire
